smg_scan_scheduler: RTL and testbench

//  Time-multiplexes the 4-digit 7-segment display of the snake game between the live score and the

---
 rtl/smg_scan_scheduler.sv | 139 +++++++++++++
 tb/tb_smg_scan_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/smg_scan_scheduler.sv
// Four-digit 7-segment scan scheduler for the snake game: multiplexes live score and high score,
// blanks between digits to suppress ghosting, blinks the score in END and keeps the high score.
module smg_scan_scheduler #(
    parameter int SCAN_TICKS  = 50_000,
    parameter int BLANK_TICKS = 500,
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    input  logic [2:0] Game_status,
    input  logic [7:0] Score_bcd,
    output logic [7:0] Smg_duan,
    output logic [3:0] Smg_we,
    output logic [7:0] Hiscore_bcd
);

    localparam int CNT_W   = $clog2(SCAN_TICKS);
    localparam int BLINK_W = $clog2(BLINK_TICKS);

    typedef enum logic [1:0] {
        S_START,
        S_PLAY,
        S_END
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [7:0]         hiscore_q, hiscore_d;
    logic [7:0]         glyph_q, glyph_d;
    logic [7:0]         duan_q, duan_d;
    logic [3:0]         we_q, we_d;
    logic [7:0]         live_glyph;

    // Common-anode, active-low segment codes; non-BCD nibbles render dark.
    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        mode_d      = S_START;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        hiscore_d   = hiscore_q;
        glyph_d     = glyph_q;
        live_glyph  = 8'hBF;
        we_d        = 4'b1111;
        duan_d      = 8'hFF;

        case (Game_status)
            3'b010:  mode_d = S_PLAY;
            3'b100:  mode_d = S_END;
            default: mode_d = S_START;
        endcase

        if (cnt_q == CNT_W'(SCAN_TICKS - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (mode_q == S_END) begin
            if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                phase_d     = phase_q;
            end
        end

        // Compare only on the entry cycle so a long END never re-latches.
        if (mode_d == S_END && mode_q != S_END && Score_bcd > hiscore_q)
            hiscore_d = Score_bcd;

        if (mode_q != S_START) begin
            case (idx_q)
                2'd0:    live_glyph = (mode_q == S_END && !phase_q) ? 8'hFF : seg7(Score_bcd[3:0]);
                2'd1:    live_glyph = (mode_q == S_END && !phase_q) ? 8'hFF : seg7(Score_bcd[7:4]);
                2'd2:    live_glyph = seg7(hiscore_q[3:0]);
                default: live_glyph = seg7(hiscore_q[7:4]);
            endcase
        end

        // Glyph is frozen at the end of the blank window so the digit cannot glitch mid-slot.
        if (cnt_q == CNT_W'(BLANK_TICKS - 1))
            glyph_d = live_glyph;

        if (cnt_q >= CNT_W'(BLANK_TICKS)) begin
            we_d   = ~(4'b0001 << idx_q);
            duan_d = glyph_q;
        end
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q      <= S_START;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            hiscore_q   <= 8'h00;
            glyph_q     <= 8'hFF;
            duan_q      <= 8'hFF;
            we_q        <= 4'b1111;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge state.
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hiscore_q   <= hiscore_d;
            glyph_q     <= glyph_d;
            duan_q      <= duan_d;
            we_q        <= we_d;
        end
    end

    assign Smg_duan    = duan_q;
    assign Smg_we      = we_q;
    assign Hiscore_bcd = hiscore_q;

endmodule

// File: tb/tb_smg_scan_scheduler.sv
// Scoreboard bench for smg_scan_scheduler: stimulus queues the expected digit per scan slot,
// a monitor pops one entry at each slot's first lit cycle and checks slot/blank timing.
module tb_smg_scan_scheduler;

    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] status = 3'b001;
    logic [7:0] score = 8'h00;
    logic [7:0] duan;
    logic [3:0] we;
    logic [7:0] hi;

    always #5 clk = ~clk;

    smg_scan_scheduler #(
        .SCAN_TICKS (SCAN),
        .BLANK_TICKS(BLANK),
        .BLINK_TICKS(BLINK)
    ) dut (
        .Clk_50mhz  (clk),
        .Rst_n      (rst_n),
        .Game_status(status),
        .Score_bcd  (score),
        .Smg_duan   (duan),
        .Smg_we     (we),
        .Hiscore_bcd(hi)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    int          exp_idx = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    endfunction

    // Queue n upcoming slots; dash=1 shows '-' everywhere, dark=1 blanks the score digits.
    task automatic push_slots(input int n, input bit dash, input logic [7:0] sc,
                              input logic [7:0] hs, input bit dark);
        for (int i = 0; i < n; i++) begin
            logic [3:0] w;
            logic [7:0] d;
            logic [1:0] k;
            k = exp_idx[1:0];
            w = ~(4'b0001 << k);
            if (dash)
                d = 8'hBF;
            else begin
                case (k)
                    2'd0:    d = dark ? 8'hFF : seg(sc[3:0]);
                    2'd1:    d = dark ? 8'hFF : seg(sc[7:4]);
                    2'd2:    d = seg(hs[3:0]);
                    default: d = seg(hs[7:4]);
                endcase
            end
            exp_q.push_back({w, d});
            exp_idx = (exp_idx + 1) % 4;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d slots still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor
    bit          in_lit = 1'b0;
    int          lit_len = 0;
    int          blank_len = 0;
    logic [11:0] cur = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_lit    = 1'b0;
            lit_len   = 0;
            blank_len = 0;
        end else if (we == 4'b1111) begin
            if (in_lit)
                check("lit_len", 12'(lit_len), 12'(SCAN - BLANK));
            in_lit  = 1'b0;
            lit_len = 0;
            blank_len++;
            check("blank_duan", {4'h0, duan}, 12'h0FF);
        end else begin
            if (!in_lit) begin
                check("blank_len", 12'(blank_len), 12'(BLANK));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_slot: got we=%b duan=%h, expected no slot", we, duan);
                    cur = 12'h000;
                end else begin
                    cur = exp_q.pop_front();
                end
                in_lit    = 1'b1;
                blank_len = 0;
            end
            lit_len++;
            check("slot", {we, duan}, cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", {8'h00, we}, 12'h00F);
        check("rst_duan", {4'h0, duan}, 12'h0FF);
        check("rst_hi", {4'h0, hi}, 12'h000);

        // START: dashes, scan wraps past idx3
        exp_idx = 0;
        push_slots(5, 1'b1, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        wait_drain();

        // PLAY, score 37, high score 00
        status = 3'b010;
        score  = 8'h37;
        push_slots(4, 1'b0, 8'h37, 8'h00, 1'b0);
        wait_drain();

        // END entry: high score latches 37 one cycle later; blink 5 slots lit, 5 dark, 5 lit
        status = 3'b100;
        push_slots(5, 1'b0, 8'h37, 8'h37, 1'b0);
        push_slots(5, 1'b0, 8'h37, 8'h37, 1'b1);
        push_slots(5, 1'b0, 8'h37, 8'h37, 1'b0);
        #1;
        check("hi_before_entry", {4'h0, hi}, 12'h000);
        @(posedge clk);
        #2;
        check("hi_after_entry", {4'h0, hi}, 12'h037);
        wait_drain();

        // Lower score replay: high score unchanged
        status = 3'b010;
        score  = 8'h25;
        push_slots(4, 1'b0, 8'h25, 8'h37, 1'b0);
        wait_drain();
        status = 3'b100;
        push_slots(5, 1'b0, 8'h25, 8'h37, 1'b0);
        @(posedge clk);
        #2;
        check("hi_lower", {4'h0, hi}, 12'h037);
        wait_drain();

        // Equal score replay: high score unchanged
        status = 3'b010;
        score  = 8'h37;
        push_slots(4, 1'b0, 8'h37, 8'h37, 1'b0);
        wait_drain();
        status = 3'b100;
        push_slots(5, 1'b0, 8'h37, 8'h37, 1'b0);
        @(posedge clk);
        #2;
        check("hi_equal", {4'h0, hi}, 12'h037);
        wait_drain();

        // Non-one-hot status behaves as START
        status = 3'b011;
        push_slots(4, 1'b1, 8'h00, 8'h00, 1'b0);
        wait_drain();
        status = 3'b000;
        score  = 8'h3A;
        push_slots(4, 1'b1, 8'h00, 8'h00, 1'b0);
        wait_drain();

        // Invalid units nibble renders blank
        status = 3'b010;
        push_slots(4, 1'b0, 8'h3A, 8'h37, 1'b0);
        wait_drain();

        // Reset asserted mid-slot while in END
        status = 3'b100;
        score  = 8'h12;
        push_slots(2, 1'b0, 8'h12, 8'h37, 1'b0);
        wait_drain();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", {8'h00, we}, 12'h00F);
        check("midrst_duan", {4'h0, duan}, 12'h0FF);
        check("midrst_hi", {4'h0, hi}, 12'h000);
        status = 3'b010;
        exp_q.delete();
        exp_idx = 0;
        repeat (2) @(negedge clk);
        push_slots(4, 1'b0, 8'h12, 8'h00, 1'b0);
        rst_n = 1'b1;
        wait_drain();
        check("hi_after_rst", {4'h0, hi}, 12'h000);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
